mem_port_master: RTL and testbench
==================================

# mem_port_master

Initiator side of the 16-bit data memory port. It accepts load and store requests from the MEM stage over a valid/ready handshake and buffers stores in a small posted-write store buffer (SB). It drives `mem_read`/`mem_write`/`rw_addr`/`w_data` toward the data memory and returns load data to the pipeline as a one-cycle response pulse.

## Interface
- `ADDR_W`, 8: word address width; 256 × 16-bit words.
- `DATA_W`, 16: data word width.
- `SB_DEPTH`, 4: store buffer entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; everything updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  store data.
- `rsp_valid`  out  1  one-cycle load-response pulse; no backpressure.
- `rsp_rdata`  out  DATA_W  load data; valid when `rsp_valid` is high.
- `sb_empty`  out  1  store buffer empty; used for fence and halt.
- `mem_gnt`  in  1  memory port granted; when low, no access is launched.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `rw_addr`  out  32  memory address; `req_addr` zero-extended.
- `w_data`  out  32  memory write data; zero-extended.
- `r_data`  in  32  memory read data; only bits [15:0] are used.

## Operation
- **FSM states:** IDLE, LOAD, DRAIN_WAIT.
  - DRAIN_WAIT exists only when `STORE_FWD_EN` is undefined.
- **Stores:** accepted when not full.
  - An accepted store is pushed into the SB at that edge.
  - The SB is FIFO; memory write order equals acceptance order.
- **Port arbitration:** each cycle the memory port does exactly one of:
  - read (state LOAD),
  - write of the SB head,
  - nothing.
- `mem_read` and `mem_write` are never high together.
- **Drain:**
  - At an edge where the next state is not LOAD, `mem_gnt` is 1 and the SB is non-empty, the head is popped.
  - The popped entry is driven for the following cycle with `mem_write=1`, `rw_addr=addr`, `w_data=data`.
  - Drain rate is at most one entry per cycle.
- **Loads:** only one load is outstanding.
  - Load miss: state moves IDLE→LOAD.
  - In LOAD, `mem_read=1` and `rw_addr` = the load address.
  - `r_data[15:0]` is captured at the end of LOAD, `rsp_valid` pulses, and the state returns to IDLE.
  - LOAD waits while `mem_gnt=0`: `mem_read` stays 0 and state stays LOAD.
- **req_ready:** high only when not in reset, state is IDLE, and the SB is not full.
  - A load is accepted even when the SB is full? No — `req_ready` is low whenever the SB is full, for both loads and stores.
- **Idle port:** when neither strobe is high, `rw_addr`/`w_data` hold their last value.
- **Reset:**
  - Outputs: `req_ready=0` in the reset cycle, `rsp_valid=0`, `rsp_rdata=0`, `mem_read=0`, `mem_write=0`, `rw_addr=0`, `w_data=0`, `sb_empty=1`.
  - Internal: SB pointers are cleared and pending stores are discarded; state goes to IDLE.
  - Reset mid-operation drops any in-flight load response.

## Timing
- **Store accepted at edge N, SB empty, `mem_gnt=1`:** `mem_write` is high in cycle N+1; `sb_empty` is 1 again in cycle N+1.
- **Load miss accepted at edge N, `mem_gnt=1`:** `mem_read` is high in cycle N+1; `rsp_valid` and `rsp_rdata` are valid in cycle N+2.
- **Forwarded load accepted at edge N:** `rsp_valid` in cycle N+1; no memory access.
- **Full SB:** `req_ready` deasserts in the cycle after the edge at which the SB becomes full, and rises in the cycle after the pop edge.
- **Simultaneous push and pop:** push and pop at the same edge are legal; occupancy is unchanged.

## Configuration
- **`STORE_FWD_EN` defined:** an accepted load compares its address against all valid SB entries.
  - Youngest match wins and returns data with 1-cycle latency, with no memory access.
  - A miss goes straight to LOAD; draining pauses while the read occupies the port.
- **`STORE_FWD_EN` undefined:** no compare logic.
  - A load accepted with the SB non-empty enters DRAIN_WAIT and waits until the SB is empty and the last write cycle has completed, then goes to LOAD.
  - This gives strict memory ordering.

## Structure
- **Package `mips16_mem_pkg`:** `ADDR_W`/`DATA_W` defaults, the `sb_entry_t` struct {addr, data}, and the FSM state enum.
- **Sub-module `store_buf`:** FIFO with push/pop, full/empty, and the youngest-first address match port; the match port is compiled only under `STORE_FWD_EN`.

## Test plan
- Reset: assert `rst` for 2 cycles → all outputs 0, `sb_empty=1`; `req_ready=1` in the first cycle after reset.
- Store 0x10←0xBEEF with `mem_gnt=1` → next cycle `mem_write=1`, `rw_addr=0x10`, `w_data=0xBEEF`, `mem_read=0`.
- Load 0x05 on a memory initialised to data=index → `mem_read=1` at N+1; `rsp_valid=1` with `rsp_rdata=0x0005` at N+2.
- `mem_gnt=0`, issue 5 stores → 4 accepted and `req_ready=0`; raise `mem_gnt` → writes occur in acceptance order, one per cycle.
- `mem_gnt=0`, store 0x20←0x1234, then load 0x20:
  - With `STORE_FWD_EN` → `rsp_rdata=0x1234` at N+1 with no `mem_read`.
  - Without → no response until `mem_gnt=1`; the write occurs before the read; response is 0x1234.
- 3 stores pending with `mem_gnt=0`, pulse `rst` → `sb_empty=1`; after raising `mem_gnt`, no `mem_write` occurs.

Source files
------------

// File: rtl/mips16_mem_pkg.sv
// rtl/mips16_mem_pkg.sv - shared widths, store buffer entry and FSM states for mem_port_master
package mips16_mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

`ifdef STORE_FWD_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN_WAIT
    } state_t;
`endif

endpackage

// File: rtl/mem_port_master_store_buf.sv
// rtl/mem_port_master_store_buf.sv - posted-write store FIFO; STORE_FWD_EN adds a youngest-first address match port
module store_buf
    import mips16_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  sb_entry_t         push_entry,
    input  logic              pop,
    output sb_entry_t         head,
    output logic              full,
    output logic              empty
`ifdef STORE_FWD_EN
    ,
    input  logic [ADDR_W-1:0] match_addr,
    output logic              match_hit,
    output logic [DATA_W-1:0] match_data
`endif
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t   entries [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = entries[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr[PW-1:0]] <= push_entry;
    end

`ifdef STORE_FWD_EN
    logic [PW:0]   count;
    logic [PW-1:0] idx;

    assign count = wr_ptr - rd_ptr;

    // Scan oldest to youngest so a later hit overrides an earlier one.
    always_comb begin
        match_hit  = 1'b0;
        match_data = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr[PW-1:0] + PW'(i);
            if (((PW+1)'(i) < count) && (entries[idx].addr == match_addr)) begin
                match_hit  = 1'b1;
                match_data = entries[idx].data;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_port_master.sv
// rtl/mem_port_master.sv - data memory port initiator with posted store buffer; STORE_FWD_EN enables load forwarding
module mem_port_master
    import mips16_mem_pkg::*;
#(
    parameter int ADDR_W   = mips16_mem_pkg::ADDR_W,
    parameter int DATA_W   = mips16_mem_pkg::DATA_W,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sb_empty,
    input  logic              mem_gnt,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       rw_addr,
    output logic [31:0]       w_data,
    input  logic [31:0]       r_data
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] ld_addr, ld_addr_next;
    logic              accept, st_acc, ld_acc;
    logic              drain, push, pop;
    logic              sb_full;
    sb_entry_t         sb_head, in_entry, drain_entry;
    logic              unused_rdata;

    assign unused_rdata = ^r_data[31:DATA_W];

    assign req_ready = !rst && (state == ST_IDLE) && !sb_full;
    assign accept    = req_valid && req_ready;
    assign st_acc    = accept && req_we;
    assign ld_acc    = accept && !req_we;
    assign in_entry  = '{addr: req_addr, data: req_wdata};
    assign mem_read  = !rst && (state == ST_LOAD) && mem_gnt;

`ifdef STORE_FWD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    always_comb begin
        state_next   = state;
        ld_addr_next = ld_addr;
        case (state)
            ST_IDLE: begin
                if (ld_acc) begin
                    ld_addr_next = req_addr;
`ifdef STORE_FWD_EN
                    if (!fwd_hit) state_next = ST_LOAD;
`else
                    state_next = sb_empty ? ST_LOAD : ST_DRAIN_WAIT;
`endif
                end
            end
            ST_LOAD: if (mem_gnt) state_next = ST_IDLE;
`ifndef STORE_FWD_EN
            // Entering LOAD only once empty means the final write has already used the port.
            ST_DRAIN_WAIT: if (sb_empty) state_next = ST_LOAD;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // An accepted store with an empty buffer bypasses straight onto the port.
    assign drain       = mem_gnt && (state_next != ST_LOAD) && (!sb_empty || st_acc);
    assign drain_entry = sb_empty ? in_entry : sb_head;
    assign pop         = drain && !sb_empty;
    assign push        = st_acc && !(sb_empty && drain);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ld_addr   <= '0;
            mem_write <= 1'b0;
            rw_addr   <= '0;
            w_data    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_next;
            ld_addr   <= ld_addr_next;
            mem_write <= drain;
            rsp_valid <= 1'b0;
            if (drain) begin
                rw_addr <= 32'(drain_entry.addr);
                w_data  <= 32'(drain_entry.data);
            end else if (state_next == ST_LOAD) begin
                rw_addr <= 32'(ld_addr_next);
            end
            if ((state == ST_LOAD) && mem_gnt) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= r_data[DATA_W-1:0];
            end
`ifdef STORE_FWD_EN
            if (ld_acc && fwd_hit) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= fwd_data;
            end
`endif
        end
    end

    store_buf #(
        .DEPTH(SB_DEPTH)
    ) u_store_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (in_entry),
        .pop        (pop),
        .head       (sb_head),
        .full       (sb_full),
        .empty      (sb_empty)
`ifdef STORE_FWD_EN
        ,
        .match_addr (req_addr),
        .match_hit  (fwd_hit),
        .match_data (fwd_data)
`endif
    );

endmodule

// File: tb/tb_mem_port_master.sv
// tb/tb_mem_port_master.sv - directed scoreboard bench for mem_port_master
module tb_mem_port_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        sb_empty, mem_gnt, mem_read, mem_write;
    logic [31:0] rw_addr, w_data, r_data;

    logic [15:0] mem [256];
    logic [23:0] wq [$];
    logic [15:0] rq [$];
    int passed = 0;
    int total  = 0;

    mem_port_master dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sb_empty(sb_empty),
        .mem_gnt(mem_gnt), .mem_read(mem_read), .mem_write(mem_write),
        .rw_addr(rw_addr), .w_data(w_data), .r_data(r_data)
    );

    always #5 clk = ~clk;

    assign r_data = {16'h0, mem[rw_addr[7:0]]};

    always @(posedge clk) begin
        if (!rst && mem_write) mem[rw_addr[7:0]] <= w_data[15:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read || mem_write) chk("strobe_exclusive", 32'(mem_read && mem_write), 32'd0);
            if (mem_write) begin
                if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                else chk("write_order", {8'h0, rw_addr[7:0], w_data[15:0]}, {8'h0, wq.pop_front()});
            end
            if (rsp_valid) begin
                if (rq.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
                else chk("rsp_data", 32'(rsp_rdata), 32'(rq.pop_front()));
            end
        end
    end

    initial begin
        int accepted;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; mem_gnt = 1'b1;
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_outputs", {26'h0, rsp_valid, mem_read, mem_write, 3'b0}, 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rw_addr", rw_addr, 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_sb_empty", 32'(sb_empty), 32'd1);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Store with an empty buffer goes out the very next cycle.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 16'hBEEF;
        wq.push_back({8'h10, 16'hBEEF});
        step();
        req_valid = 1'b0;
        chk("st_mem_write", 32'(mem_write), 32'd1);
        chk("st_rw_addr", rw_addr, 32'h10);
        chk("st_w_data", w_data, 32'hBEEF);
        chk("st_mem_read", 32'(mem_read), 32'd0);
        chk("st_sb_empty", 32'(sb_empty), 32'd1);

        // Load miss: read at N+1, response at N+2.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05;
        rq.push_back(16'h0005);
        step();
        req_valid = 1'b0;
        chk("ld_mem_read", 32'(mem_read), 32'd1);
        chk("ld_rw_addr", rw_addr, 32'h05);
        chk("ld_busy_ready", 32'(req_ready), 32'd0);
        step();
        chk("ld_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ld_rsp_rdata", 32'(rsp_rdata), 32'h5);

        // Back-to-back stores with grant drain one per cycle via the bypass.
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 8'(8'h30 + i); req_wdata = 16'(16'h5000 + i);
            wq.push_back({8'(8'h30 + i), 16'(16'h5000 + i)});
            step();
            chk("b2b_rw_addr", rw_addr, 32'(8'h30 + i));
        end
        req_valid = 1'b0;
        step();

        // No grant: five stores, four fit.
        mem_gnt = 1'b0;
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 8'(8'h40 + i); req_wdata = 16'(16'hA000 + i);
            #1;
            if (req_ready) begin
                accepted++;
                wq.push_back({8'(8'h40 + i), 16'(16'hA000 + i)});
            end
            step();
        end
        req_valid = 1'b0;
        chk("full_accepted", 32'(accepted), 32'd4);
        chk("full_req_ready", 32'(req_ready), 32'd0);
        chk("full_sb_empty", 32'(sb_empty), 32'd0);
        mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_write", 32'(mem_write), 32'd1);
            chk("drain_addr", rw_addr, 32'(8'h40 + i));
            if (i == 0) chk("drain_ready_back", 32'(req_ready), 32'd1);
        end
        step();
        chk("drain_done_write", 32'(mem_write), 32'd0);
        chk("drain_done_empty", 32'(sb_empty), 32'd1);

        // Load after a pending store to the same address.
        mem_gnt = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 16'h1234;
        wq.push_back({8'h20, 16'h1234});
        step();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20;
        rq.push_back(16'h1234);
        step();
        req_valid = 1'b0;
`ifdef STORE_FWD_EN
        chk("fwd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("fwd_rsp_rdata", 32'(rsp_rdata), 32'h1234);
        chk("fwd_no_read", 32'(mem_read), 32'd0);
        mem_gnt = 1'b1;
        step();
        chk("fwd_late_write", 32'(mem_write), 32'd1);
        step();
`else
        for (int i = 0; i < 3; i++) begin
            chk("order_wait_rsp", 32'(rsp_valid), 32'd0);
            chk("order_wait_port", {30'h0, mem_read, mem_write}, 32'd0);
            step();
        end
        mem_gnt = 1'b1;
        step();
        chk("order_write_first", {30'h0, mem_read, mem_write}, 32'd1);
        chk("order_write_addr", rw_addr, 32'h20);
        step();
        chk("order_read_next", {30'h0, mem_read, mem_write}, 32'd2);
        chk("order_read_addr", rw_addr, 32'h20);
        step();
        chk("order_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("order_rsp_rdata", 32'(rsp_rdata), 32'h1234);
`endif
        step();

        // Reset discards pending stores.
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 8'(8'h60 + i); req_wdata = 16'(16'hC000 + i);
            step();
        end
        req_valid = 1'b0;
        chk("pend_sb_empty", 32'(sb_empty), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_discard_empty", 32'(sb_empty), 32'd1);
        mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_write", 32'(mem_write), 32'd0);
        end

        for (int i = 0; i < 20 && (wq.size() != 0 || rq.size() != 0); i++) step();
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
